// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding,
// index-width helper and the default forced-release hold limit.
// Optional feature macro used by the arbiter: RR_ARBITER_TIMEOUT_EN.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned HOLD_MAX_DEF = 16;

    // Width of an index into n requesters (at least 1 bit).
    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// falling back to the lowest requesting index overall.
// Ports:
//   req    in  N     request vector
//   ptr    in  ID_W  highest-priority index
//   winner out ID_W  chosen index (0 when nothing requests)
//   any    out 1     at least one request present
module rr_mask_pick
    import arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [id_w(N)-1:0] ptr,
    output logic [id_w(N)-1:0] winner,
    output logic               any
);

    localparam int unsigned ID_W = id_w(N);

    logic [ID_W-1:0] m_win;
    logic [ID_W-1:0] u_win;
    logic            m_any;

    // Scan high to low so the last hit is the lowest index.
    always_comb begin
        m_win = '0;
        u_win = '0;
        m_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                u_win = ID_W'(i);
                if (i >= int'(ptr)) begin
                    m_win = ID_W'(i);
                    m_any = 1'b1;
                end
            end
        end
        winner = m_any ? m_win : u_win;
        any    = |req;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until release.
// Optional forced release after HOLD_MAX cycles when RR_ARBITER_TIMEOUT_EN
// is defined (adds the timeout output).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req       in  N    level requests
//   done      in  N    release pulse, only the owner's bit is honoured
//   gnt       out N    one-hot grant, zero when idle
//   gnt_id    out ID_W owner index, holds last owner when idle
//   gnt_valid out 1    |gnt
//   timeout   out 1    one-cycle pulse after a forced release (macro only)
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       done,
    output logic [N-1:0]       gnt,
    output logic [id_w(N)-1:0] gnt_id,
    output logic               gnt_valid
`ifdef RR_ARBITER_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    localparam int unsigned ID_W = id_w(N);

    // Elaboration-time parameter sanity.
    if (N < 2) begin : g_chk_n
        $error("rr_arbiter: N must be >= 2");
    end
    if (HOLD_MAX < 2) begin : g_chk_hold
        $error("rr_arbiter: HOLD_MAX must be >= 2");
    end

    arb_state_e      state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [ID_W-1:0] gnt_id_nxt;
    logic [ID_W-1:0] rot_ptr;
    logic [ID_W-1:0] pick_ptr;
    logic [ID_W-1:0] pick_win;
    logic            pick_any;
    logic            own_done;
    logic            own_req;
    logic            rel;
    logic            grant_new;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(HOLD_MAX);
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             expired;
    logic             timeout_nxt;
`endif

    // Pointer after the current owner releases; N-1 wraps to 0.
    assign rot_ptr  = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
    // While granted, the pick only matters at release, so use the rotated pointer.
    assign pick_ptr = (state == ARB_GRANT) ? rot_ptr : ptr;

    rr_mask_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (pick_win),
        .any    (pick_any)
    );

    // Next-state, pointer and grant computation.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        grant_new  = 1'b0;
        rel        = 1'b0;
        own_done   = done[gnt_id];
        own_req    = req[gnt_id];
`ifdef RR_ARBITER_TIMEOUT_EN
        expired      = (hold_cnt == CNT_W'(HOLD_MAX - 1));
        timeout_nxt  = 1'b0;
        hold_cnt_nxt = hold_cnt;
`endif
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_new = 1'b1;
                end
            end
            ARB_GRANT: begin
                rel = own_done | ~own_req;
`ifdef RR_ARBITER_TIMEOUT_EN
                rel = rel | expired;
`endif
                if (rel) begin
                    ptr_nxt = rot_ptr;
`ifdef RR_ARBITER_TIMEOUT_EN
                    timeout_nxt = expired & own_req & ~own_done;
`endif
                    if (pick_any) begin
                        grant_new = 1'b1;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = ARB_IDLE;
                    end
                end else begin
`ifdef RR_ARBITER_TIMEOUT_EN
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
`endif
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (grant_new) begin
            gnt_nxt    = N'(1) << pick_win;
            gnt_id_nxt = pick_win;
            state_nxt  = ARB_GRANT;
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt_nxt = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= |gnt_nxt;
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt  <= hold_cnt_nxt;
            timeout   <= timeout_nxt;
`endif
        end
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters. Each requester holds a request line. The arbiter issues a registered one-hot grant, holds it until the owner releases, then rotates priority so every persistent requester is served within N grants. It sits in front of the encoder/mux resources in the datapath and is the sequencing owner of that resource.

## Interface
- N, default 4: number of requesters; N ≥ 2, power of two not required.
- HOLD_MAX, default 16: maximum granted cycles before forced release. Used only when timeout is compiled in. HOLD_MAX ≥ 2.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req  in  N  request per requester, level-sensitive.
- done  in  N  release pulse; only the bit of the current owner is honoured.
- gnt  out  N  one-hot grant, registered; all-zero when idle.
- gnt_id  out  ID_W  index of owner, ID_W = $clog2(N); holds last owner when idle.
- gnt_valid  out  1  equals |gnt.
- timeout  out  1  one-cycle pulse on forced release; present only with the timeout macro.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner.
- Rotating pointer ptr (ID_W bits) names the highest-priority index.
- Pick function, evaluated on the current req:
  - masked = req & {bits at index ≥ ptr}.
  - Winner = lowest set index of masked if masked ≠ 0, else lowest set index of req.
- IDLE:
  - If |req, register gnt = onehot(winner), gnt_id = winner, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT release events:
  - done[gnt_id] = 1, or req[gnt_id] = 0, or (with timeout) hold count expired.
  - Simultaneous events count as a single release.
- On release:
  - ptr ← (gnt_id + 1) mod N; index N−1 wraps to 0.
  - Pick is evaluated with the new ptr in the same cycle, so grants hand over back-to-back with no idle cycle.
  - If no request is pending, gnt ← 0 and the state goes to IDLE.
  - The releasing requester has lowest priority. It wins again only if it is the sole requester with req still high.
- done bits of non-owners are ignored in every state. done in IDLE is ignored.
- A new request never preempts the current owner.
- Reset values:
  - gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0.
  - ptr = 0, state IDLE, hold count = 0.
- Reset asserted mid-grant: grant drops at that edge and no release side effects (ptr update) occur.

## Timing
- Request-to-grant latency: 1 cycle. req sampled high at edge k gives gnt high after edge k.
- Release-to-next-grant: 0 idle cycles. The release edge and the new grant coincide.
- Minimum tenure: 1 cycle. Owner may assert done in its first granted cycle.
- gnt, gnt_id and gnt_valid change only at clock edges. The outputs have no combinational path from req or done.
- Fairness: with all N requesting continuously, each is granted exactly once per N consecutive grants.

## Configuration
- RR_ARBITER_TIMEOUT_EN defined:
  - Hold counter of width $clog2(HOLD_MAX) is cleared on every new grant and increments each GRANT cycle.
  - When count = HOLD_MAX−1 at an edge with no other release, the arbiter force-releases. The owner therefore holds for exactly HOLD_MAX cycles.
  - Rotation rules are the same as for a normal release.
  - timeout pulses high for one cycle, coincident with the post-release cycle.
- Not defined: no counter, no timeout port, tenure unbounded.

## Structure
- Shared package arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_GRANT);
  - an ID width helper function;
  - the HOLD_MAX default constant.
- One sub-module, rr_mask_pick: purely combinational.
  - Inputs: req, ptr.
  - Outputs: winner index and any-valid, implementing the masked/unmasked lowest-index pick.
  - The top level holds the FSM, pointer, output registers and optional counter.

## Test plan
- Reset: rst_n = 0 for 2 cycles with req = 4'b1111 → gnt = 0, gnt_valid = 0, gnt_id = 0 throughout; first grant after reset deassertion is index 0.
- Single requester: req = 4'b0100 → gnt = 4'b0100, gnt_id = 2 one edge later; pulse done[2] → gnt = 0 next edge; then req = 4'b1111 gives grant to index 3 (ptr = 3).
- Full rotation: req = 4'b1111 held, owner pulses done in each first granted cycle → gnt_id sequence 0, 1, 2, 3, 0 on consecutive cycles with gnt_valid continuously high.
- Wrap and ignored done: after index 3 releases, req = 4'b0011 with done[1] pulsed while 0 owns → done ignored, 0 retains grant; 0 drops req → index 1 granted the same edge.
- Sole re-grant: only req[1] high, done[1] pulsed with req[1] still high → index 1 re-granted back-to-back, ptr = 2.
- Timeout (macro on, HOLD_MAX = 4): req = 4'b0110, no done → index 1 granted 4 cycles, forced release, timeout = 1 for one cycle, index 2 granted the same cycle; macro off → index 1 held indefinitely.
